// File: rtl/mem_dc_stream_fetch.sv
// DC coefficient streamer: reads coefficient 0 of each block and emits it (or its delta) on valid/ready.
// First beat 2+RD_LAT cycles after start; reads are throttled so the small return FIFO never overflows.

module mem_dc_stream_fetch_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 3,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             i_push_vld,
  input  logic [W-1:0]     i_push_dat,
  input  logic             i_pop_rdy,
  output logic             o_pop_vld,
  output logic [W-1:0]     o_pop_dat,
  output logic [CNT_W-1:0] o_count
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_cnt;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_do_pop  = i_pop_rdy && (r_cnt != '0);
  // A push into a full FIFO is legal only when the head leaves in the same cycle.
  assign w_do_push = i_push_vld && ((r_cnt != CNT_W'(DEPTH)) || w_do_pop);
  assign o_pop_vld = (r_cnt != '0);
  assign o_pop_dat = r_mem[r_rptr];
  assign o_count   = r_cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wptr] <= i_push_dat;
        r_wptr        <= (r_wptr == PTR_W'(DEPTH - 1)) ? '0 : r_wptr + 1'b1;
      end
      if (w_do_pop) r_rptr <= (r_rptr == PTR_W'(DEPTH - 1)) ? '0 : r_rptr + 1'b1;
      if (w_do_push && !w_do_pop)      r_cnt <= r_cnt + 1'b1;
      else if (w_do_pop && !w_do_push) r_cnt <= r_cnt - 1'b1;
    end
  end
endmodule

module mem_dc_stream_fetch #(
  parameter int DATA_W       = 32,
  parameter int BLOCK_PIXELS = 64,
  parameter int MAX_BLOCKS   = 32,
  parameter int ADDR_W       = 11,
  parameter int RD_LAT       = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [31:0]       block_num,
  input  logic              diff_en,
  output logic              busy,
  output logic              done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              dc_valid,
  input  logic              dc_ready,
  output logic [DATA_W-1:0] dc_data,
  output logic [31:0]       dc_index,
  output logic              dc_last
);
  localparam int DEPTH = RD_LAT + 2;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int ENT_W = DATA_W + 33;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [31:0]       r_n;
  logic [31:0]       r_rd_idx;
  logic [31:0]       r_ret_idx;
  logic              r_diff;
  logic [DATA_W-1:0] r_prev;
  logic [RD_LAT-1:0] r_vpipe;

  logic              w_accept;
  logic [31:0]       w_n_clamp;
  logic [CNT_W-1:0]  w_in_flight;
  logic [CNT_W-1:0]  w_fifo_cnt;
  logic              w_issue;
  logic              w_push;
  logic              w_pop;
  logic              w_fifo_vld;
  logic [DATA_W-1:0] w_push_dat;
  logic              w_push_last;
  logic [ENT_W-1:0]  w_head;

  assign w_accept  = start && (r_state == S_IDLE);
  assign w_n_clamp = (block_num > 32'(MAX_BLOCKS)) ? 32'(MAX_BLOCKS) : block_num;

  always_comb begin
    w_in_flight = '0;
    for (int i = 0; i < RD_LAT; i++) w_in_flight = w_in_flight + CNT_W'(r_vpipe[i]);
  end

  // Reads in flight plus buffered entries are bounded by the FIFO depth, so returns never drop.
  assign w_issue   = (r_state == S_FETCH) &&
                     ((32'(w_in_flight) + 32'(w_fifo_cnt)) < 32'(DEPTH));
  assign mem_rd_en = w_issue;
  assign mem_addr  = w_issue ? ADDR_W'(r_rd_idx * BLOCK_PIXELS) : '0;

  assign w_push      = r_vpipe[RD_LAT-1];
  assign w_push_dat  = r_diff ? (mem_rd_data - r_prev) : mem_rd_data;
  assign w_push_last = (r_ret_idx == r_n - 32'd1);
  assign w_pop       = w_fifo_vld && dc_ready;

  assign busy     = (r_state != S_IDLE);
  assign done     = (r_state == S_DONE);
  assign dc_valid = w_fifo_vld;
  assign {dc_last, dc_index, dc_data} = w_head;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = (w_n_clamp == 32'd0) ? S_DONE : S_FETCH;
      S_FETCH: if (w_issue && (r_rd_idx == r_n - 32'd1)) w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_pop && dc_last) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_n       <= '0;
      r_rd_idx  <= '0;
      r_ret_idx <= '0;
      r_diff    <= 1'b0;
      r_prev    <= '0;
      r_vpipe   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_vpipe <= (r_vpipe << 1) | RD_LAT'(w_issue);
      if (w_accept) begin
        r_n       <= w_n_clamp;
        r_diff    <= diff_en;
        r_prev    <= '0;
        r_rd_idx  <= '0;
        r_ret_idx <= '0;
      end else begin
        if (w_issue) r_rd_idx <= r_rd_idx + 32'd1;
        if (w_push) begin
          r_prev    <= mem_rd_data;
          r_ret_idx <= r_ret_idx + 32'd1;
        end
      end
    end
  end

  mem_dc_stream_fetch_fifo #(
    .W     (ENT_W),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clock      (clock),
    .reset_n    (reset_n),
    .i_push_vld (w_push),
    .i_push_dat ({w_push_last, r_ret_idx, w_push_dat}),
    .i_pop_rdy  (dc_ready),
    .o_pop_vld  (w_fifo_vld),
    .o_pop_dat  (w_head),
    .o_count    (w_fifo_cnt)
  );
endmodule

// File: tb/tb_mem_dc_stream_fetch.sv
// Bench for mem_dc_stream_fetch: RAM model with RD_LAT latency, vector table and a queue-based reference.
module tb_mem_dc_stream_fetch;
  localparam int LAT = 3;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start;
  logic [31:0] block_num;
  logic        diff_en;
  logic        busy, done, mem_rd_en;
  logic [10:0] mem_addr;
  logic [31:0] mem_rd_data;
  logic        dc_valid, dc_ready, dc_last;
  logic [31:0] dc_data, dc_index;

  always #5 clock = ~clock;

  mem_dc_stream_fetch #(.RD_LAT(LAT)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .block_num(block_num),
    .diff_en(diff_en), .busy(busy), .done(done), .mem_rd_en(mem_rd_en),
    .mem_addr(mem_addr), .mem_rd_data(mem_rd_data), .dc_valid(dc_valid),
    .dc_ready(dc_ready), .dc_data(dc_data), .dc_index(dc_index), .dc_last(dc_last)
  );

  logic [31:0] ram [0:2047];
  logic [31:0] dpipe [0:LAT-1];
  always @(posedge clock) begin
    dpipe[0] <= ram[mem_addr];
    for (int i = 1; i < LAT; i++) dpipe[i] <= dpipe[i-1];
  end
  assign mem_rd_data = dpipe[LAT-1];

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct { logic [31:0] d; int idx; bit last; } beat_t;
  typedef struct {
    int nblk; bit diff; int pat; int pct; int rs; int exp_beats;
    bit chk; logic [31:0] d0; logic [31:0] d1;
  } vec_t;

  beat_t exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  function automatic bit pick(input int pct);
    return $urandom_range(99) < pct;
  endfunction

  task automatic fill(input int pat);
    for (int k = 0; k < 32; k++) ram[k*64] = (pat == 0) ? 32'(100 + k) : $urandom;
    if (pat == 1) begin
      ram[0]  = 32'd5;
      ram[64] = 32'd2;
    end
  endtask

  task automatic run_vec(input vec_t v);
    int n, st, first, donec, issued, popped, maxout, lastpop, firstpop, hi;
    logic [31:0] prev, val, hd;
    logic [31:0] cap [2];
    bit hl, stall;
    beat_t b;
    n = (v.nblk > 32) ? 32 : v.nblk;
    fill(v.pat);
    exp_q.delete();
    prev = 0;
    for (int k = 0; k < n; k++) begin
      val = ram[k*64];
      exp_q.push_back('{d: (v.diff ? val - prev : val), idx: k, last: (k == n - 1)});
      prev = val;
    end
    first = -1; donec = -1; issued = 0; popped = 0; maxout = 0;
    lastpop = 0; firstpop = 0; stall = 0; hl = 0; hi = 0; hd = 0;
    cap[0] = 0; cap[1] = 0;
    @(posedge clock); #1;
    block_num = v.nblk; diff_en = v.diff; start = 1'b1; dc_ready = pick(v.pct); st = cyc;
    for (int c = 0; c < 600 && donec < 0; c++) begin
      if (c > 0) begin
        @(posedge clock); #1;
        start = (c == v.rs);
        if (c == v.rs) begin
          block_num = 2;
          diff_en = !v.diff;
        end
        dc_ready = pick(v.pct);
      end
      @(negedge clock);
      if (stall) chk("hold", {dc_valid, dc_last, dc_index, dc_data}, {1'b1, hl, hi, hd});
      if (mem_rd_en) begin
        chk("addr", 96'(mem_addr), 96'(issued * 64));
        issued++;
      end
      if (issued - popped > maxout) maxout = issued - popped;
      if (dc_valid && first < 0) first = cyc - st;
      if (dc_valid && dc_ready) begin
        chk("beat_expected", 96'(exp_q.size() > 0), 96'(1));
        if (exp_q.size() > 0) begin
          b = exp_q.pop_front();
          chk("beat", {dc_last, dc_index, dc_data}, {b.last, b.idx, b.d});
        end
        if (popped < 2) cap[popped] = dc_data;
        if (popped == 0) firstpop = cyc;
        lastpop = cyc;
        popped++;
      end
      stall = dc_valid && !dc_ready;
      hl = dc_last; hi = dc_index; hd = dc_data;
      if (done) begin
        donec = cyc;
        chk("busy_at_done", 96'(busy), 96'(1));
      end
    end
    chk("done_seen", 96'(donec >= 0), 96'(1));
    chk("beats", 96'(popped), 96'(v.exp_beats));
    chk("reads", 96'(issued), 96'(v.exp_beats));
    chk("outstanding_max5", 96'(maxout <= 5), 96'(1));
    if (v.exp_beats > 0) begin
      chk("first_latency", 96'(first), 96'(2 + LAT));
      chk("done_latency", 96'(donec - lastpop), 96'(1));
      if (v.pct == 100) chk("throughput", 96'(lastpop - firstpop), 96'(v.exp_beats - 1));
      if (v.chk) begin
        chk("data0", 96'(cap[0]), 96'(v.d0));
        chk("data1", 96'(cap[1]), 96'(v.d1));
      end
    end else begin
      chk("zero_done_latency", 96'((donec - st >= 1) && (donec - st <= 2)), 96'(1));
      chk("zero_no_valid", 96'(first), 96'(-1));
    end
    @(posedge clock); #1;
    start = 1'b0;
    @(negedge clock);
    chk("idle_after", 96'({busy, done, dc_valid}), 96'(0));
  endtask

  task automatic reset_mid();
    int pops, guard;
    pops = 0; guard = 0;
    fill(2);
    @(posedge clock); #1;
    block_num = 8; diff_en = 1'b1; start = 1'b1; dc_ready = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    while (pops < 3 && guard < 50) begin
      @(negedge clock);
      if (dc_valid && dc_ready) pops++;
      guard++;
    end
    chk("pre_reset_beats", 96'(pops), 96'(3));
    @(posedge clock); #1;
    reset_n = 1'b0;
    #1;
    chk("reset_mid_outs", 96'({busy, done, mem_rd_en, mem_addr, dc_valid, dc_data, dc_index, dc_last}), 96'(0));
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  vec_t tbl [11];
  vec_t post;

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{4,  0, 0, 100, -1, 4,  1, 32'd100, 32'd101};
    tbl[1]  = '{4,  1, 0, 100, -1, 4,  1, 32'd100, 32'd1};
    tbl[2]  = '{2,  1, 1, 100, -1, 2,  1, 32'd5,   32'hFFFF_FFFD};
    tbl[3]  = '{8,  0, 2, 50,  -1, 8,  0, 32'd0,   32'd0};
    tbl[4]  = '{8,  1, 2, 50,  -1, 8,  0, 32'd0,   32'd0};
    tbl[5]  = '{0,  0, 2, 100, -1, 0,  0, 32'd0,   32'd0};
    tbl[6]  = '{40, 0, 2, 100, -1, 32, 0, 32'd0,   32'd0};
    tbl[7]  = '{40, 1, 2, 60,  -1, 32, 0, 32'd0,   32'd0};
    tbl[8]  = '{4,  0, 0, 100, 3,  4,  1, 32'd100, 32'd101};
    tbl[9]  = '{6,  1, 2, 30,  2,  6,  0, 32'd0,   32'd0};
    tbl[10] = '{1,  1, 2, 100, -1, 1,  0, 32'd0,   32'd0};
    post    = '{5,  1, 0, 100, -1, 5,  1, 32'd100, 32'd1};

    for (int a = 0; a < 2048; a++) ram[a] = $urandom;
    reset_n = 1'b0; start = 1'b0; block_num = 0; diff_en = 1'b0; dc_ready = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("reset_outs", 96'({busy, done, mem_rd_en, mem_addr, dc_valid, dc_data, dc_index, dc_last}), 96'(0));
    @(posedge clock); #1;
    reset_n = 1'b1;

    for (int t = 0; t < 11; t++) run_vec(tbl[t]);
    reset_mid();
    run_vec(post);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
